// File: rtl/intersection_phase_scheduler.sv
// Intersection-level phase sequencer for an NS/EW crossing with a pedestrian walk phase.
// Moore FSM; every lamp is a register decoded from the next phase, so no input reaches an output combinationally.
module intersection_phase_scheduler #(
  parameter int unsigned GREEN_MIN  = 4,
  parameter int unsigned GREEN_MAX  = 12,
  parameter int unsigned YELLOW_CYC = 2,
  parameter int unsigned ALLRED_CYC = 1,
  parameter int unsigned WALK_CYC   = 6,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_ns,
  input  logic       sensor_ew,
  input  logic       ped_req,
  output logic [2:0] phase,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_ack
);

  typedef enum logic [2:0] {
    PH_ALLRED    = 3'd0,
    PH_NS_GREEN  = 3'd1,
    PH_NS_YELLOW = 3'd2,
    PH_EW_GREEN  = 3'd3,
    PH_EW_YELLOW = 3'd4,
    PH_PED_WALK  = 3'd5
  } phase_e;

  // Dwell limits as "cycles held so far" thresholds, one bit wider than the counter.
  localparam logic [CNT_W:0] GMIN_N   = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0] GMAX_N   = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0] YEL_N    = (CNT_W+1)'(YELLOW_CYC);
  localparam logic [CNT_W:0] ALLRED_N = (CNT_W+1)'(ALLRED_CYC);
  localparam logic [CNT_W:0] WALK_N   = (CNT_W+1)'(WALK_CYC);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             req_ns_q, req_ns_d;
  logic             req_ew_q, req_ew_d;
  logic             req_ped_q, req_ped_d;
  logic             last_ew_q, last_ew_d;
  logic             after_walk_q, after_walk_d;
  logic             ns_red_q, ns_red_d;
  logic             ns_yellow_q, ns_yellow_d;
  logic             ns_green_q, ns_green_d;
  logic             ew_red_q, ew_red_d;
  logic             ew_yellow_q, ew_yellow_d;
  logic             ew_green_q, ew_green_d;
  logic             walk_q, walk_d;
  logic             ped_ack_q, ped_ack_d;

  logic             pend_ns_s, pend_ew_s, pend_ped_s;
  logic             entry_s;
  logic [CNT_W:0]   elapsed_s;

  assign pend_ns_s  = req_ns_q | sensor_ns;
  assign pend_ew_s  = req_ew_q | sensor_ew;
  assign pend_ped_s = req_ped_q | ped_req;
  assign elapsed_s  = {1'b0, dwell_q} + {{CNT_W{1'b0}}, 1'b1};

  // Next-phase selection.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_ALLRED: begin
        if (elapsed_s >= ALLRED_N) begin
          // Directly after a walk, waiting vehicles go before a fresh pedestrian request.
          if (pend_ped_s && !(after_walk_q && (pend_ns_s || pend_ew_s))) begin
            phase_d = PH_PED_WALK;
          end else if (pend_ns_s && pend_ew_s) begin
            phase_d = last_ew_q ? PH_NS_GREEN : PH_EW_GREEN;
          end else if (pend_ns_s) begin
            phase_d = PH_NS_GREEN;
          end else if (pend_ew_s) begin
            phase_d = PH_EW_GREEN;
          end else begin
            phase_d = PH_ALLRED;
          end
        end else begin
          phase_d = PH_ALLRED;
        end
      end
      PH_NS_GREEN: begin
        if ((elapsed_s >= GMIN_N) && (pend_ew_s || pend_ped_s) &&
            (!sensor_ns || (elapsed_s >= GMAX_N))) begin
          phase_d = PH_NS_YELLOW;
        end else begin
          phase_d = PH_NS_GREEN;
        end
      end
      PH_EW_GREEN: begin
        if ((elapsed_s >= GMIN_N) && (pend_ns_s || pend_ped_s) &&
            (!sensor_ew || (elapsed_s >= GMAX_N))) begin
          phase_d = PH_EW_YELLOW;
        end else begin
          phase_d = PH_EW_GREEN;
        end
      end
      PH_NS_YELLOW: begin
        if (elapsed_s >= YEL_N) begin
          phase_d = PH_ALLRED;
        end else begin
          phase_d = PH_NS_YELLOW;
        end
      end
      PH_EW_YELLOW: begin
        if (elapsed_s >= YEL_N) begin
          phase_d = PH_ALLRED;
        end else begin
          phase_d = PH_EW_YELLOW;
        end
      end
      PH_PED_WALK: begin
        if (elapsed_s >= WALK_N) begin
          phase_d = PH_ALLRED;
        end else begin
          phase_d = PH_PED_WALK;
        end
      end
      default: phase_d = PH_ALLRED;
    endcase
  end

  assign entry_s = (phase_d != phase_q);

  // Dwell counter, request latches and service history.
  always_comb begin
    dwell_d      = dwell_q;
    req_ns_d     = req_ns_q | sensor_ns;
    req_ew_d     = req_ew_q | sensor_ew;
    req_ped_d    = req_ped_q | ped_req;
    last_ew_d    = last_ew_q;
    after_walk_d = after_walk_q;
    if (entry_s) begin
      dwell_d = {CNT_W{1'b0}};
    end else if (dwell_q == {CNT_W{1'b1}}) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + CNT_W'(1);
    end
    // Clearing wins over a same-edge request, so that request is absorbed by the entry.
    if (entry_s) begin
      case (phase_d)
        PH_NS_GREEN: begin
          req_ns_d  = 1'b0;
          last_ew_d = 1'b0;
        end
        PH_EW_GREEN: begin
          req_ew_d  = 1'b0;
          last_ew_d = 1'b1;
        end
        PH_PED_WALK: req_ped_d = 1'b0;
        PH_ALLRED:   after_walk_d = (phase_q == PH_PED_WALK);
        default:     last_ew_d = last_ew_q;
      endcase
    end else begin
      last_ew_d = last_ew_q;
    end
  end

  // Lamp decode of the next phase, registered alongside it.
  always_comb begin
    ns_green_d  = (phase_d == PH_NS_GREEN);
    ns_yellow_d = (phase_d == PH_NS_YELLOW);
    ns_red_d    = !(ns_green_d || ns_yellow_d);
    ew_green_d  = (phase_d == PH_EW_GREEN);
    ew_yellow_d = (phase_d == PH_EW_YELLOW);
    ew_red_d    = !(ew_green_d || ew_yellow_d);
    walk_d      = (phase_d == PH_PED_WALK);
    ped_ack_d   = (phase_d == PH_PED_WALK) && (phase_q != PH_PED_WALK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_ALLRED;
      dwell_q      <= {CNT_W{1'b0}};
      req_ns_q     <= 1'b0;
      req_ew_q     <= 1'b0;
      req_ped_q    <= 1'b0;
      last_ew_q    <= 1'b1;
      after_walk_q <= 1'b0;
      ns_red_q     <= 1'b1;
      ns_yellow_q  <= 1'b0;
      ns_green_q   <= 1'b0;
      ew_red_q     <= 1'b1;
      ew_yellow_q  <= 1'b0;
      ew_green_q   <= 1'b0;
      walk_q       <= 1'b0;
      ped_ack_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      dwell_q      <= dwell_d;
      req_ns_q     <= req_ns_d;
      req_ew_q     <= req_ew_d;
      req_ped_q    <= req_ped_d;
      last_ew_q    <= last_ew_d;
      after_walk_q <= after_walk_d;
      ns_red_q     <= ns_red_d;
      ns_yellow_q  <= ns_yellow_d;
      ns_green_q   <= ns_green_d;
      ew_red_q     <= ew_red_d;
      ew_yellow_q  <= ew_yellow_d;
      ew_green_q   <= ew_green_d;
      walk_q       <= walk_d;
      ped_ack_q    <= ped_ack_d;
    end
  end

  assign phase     = phase_q;
  assign ns_red    = ns_red_q;
  assign ns_yellow = ns_yellow_q;
  assign ns_green  = ns_green_q;
  assign ew_red    = ew_red_q;
  assign ew_yellow = ew_yellow_q;
  assign ew_green  = ew_green_q;
  assign walk      = walk_q;
  assign ped_ack   = ped_ack_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed self-checking bench for intersection_phase_scheduler (default parameters).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_ns = 1'b0;
  logic       sensor_ew = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] phase;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack;
  logic [7:0] outs;

  int n_cmp = 0;
  int n_bad = 0;

  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack}
  localparam logic [7:0] O_ALLRED  = 8'b1001_0000;
  localparam logic [7:0] O_NSGRN   = 8'b0011_0000;
  localparam logic [7:0] O_NSYEL   = 8'b0101_0000;
  localparam logic [7:0] O_EWGRN   = 8'b1000_0100;
  localparam logic [7:0] O_WALK1   = 8'b1001_0011;
  localparam logic [7:0] O_WALK    = 8'b1001_0010;

  intersection_phase_scheduler dut (
    .clk(clk), .rst(rst), .sensor_ns(sensor_ns), .sensor_ew(sensor_ew), .ped_req(ped_req),
    .phase(phase), .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green), .walk(walk), .ped_ack(ped_ack)
  );

  assign outs = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sensor_ns = 1'b0;
    sensor_ew = 1'b0;
    ped_req   = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Number of consecutive cycles (from the current one) spent in phase ph, bounded.
  task automatic run_len(input logic [2:0] ph, output int n);
    n = 0;
    while (phase == ph && n < 64) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int bad_idle;
    do_reset();
    n_cmp++;
    if (phase !== 3'd0) begin n_bad++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_cmp++;
    if (outs !== O_ALLRED) begin n_bad++; $display("FAIL reset_lamps: got %b want %b", outs, O_ALLRED); end
    bad_idle = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (phase !== 3'd0 || outs !== O_ALLRED) bad_idle++;
    end
    n_cmp++;
    if (bad_idle !== 0) begin n_bad++; $display("FAIL idle_allred: %0d bad cycles, want 0", bad_idle); end
  endtask

  task automatic test_min_green();
    int n;
    do_reset();
    sensor_ns = 1'b1;
    tick();
    n_cmp++;
    if (outs !== O_NSGRN || phase !== 3'd1) begin n_bad++; $display("FAIL ns_entry: got ph %0d lamps %b want 1 %b", phase, outs, O_NSGRN); end
    // NS vehicle leaves once green; EW pulses in the second green cycle.
    sensor_ns = 1'b0;
    tick();
    sensor_ew = 1'b1;
    tick();
    sensor_ew = 1'b0;
    run_len(3'd1, n);
    n_cmp++;
    if (n + 2 !== 4) begin n_bad++; $display("FAIL ns_min_green_len: got %0d want 4", n + 2); end
    n_cmp++;
    if (outs !== O_NSYEL) begin n_bad++; $display("FAIL ns_yellow_lamps: got %b want %b", outs, O_NSYEL); end
    run_len(3'd2, n);
    n_cmp++;
    if (n !== 2) begin n_bad++; $display("FAIL ns_yellow_len: got %0d want 2", n); end
    run_len(3'd0, n);
    n_cmp++;
    if (n !== 1) begin n_bad++; $display("FAIL allred_len: got %0d want 1", n); end
    n_cmp++;
    if (phase !== 3'd3 || outs !== O_EWGRN) begin n_bad++; $display("FAIL ew_pulse_served: got ph %0d lamps %b want 3 %b", phase, outs, O_EWGRN); end
  endtask

  task automatic test_max_green();
    int n;
    do_reset();
    sensor_ns = 1'b1;
    sensor_ew = 1'b1;
    tick();
    n_cmp++;
    if (phase !== 3'd1) begin n_bad++; $display("FAIL tie_first_ns: got %0d want 1", phase); end
    run_len(3'd1, n);
    n_cmp++;
    if (n !== 12) begin n_bad++; $display("FAIL ns_max_green_len: got %0d want 12", n); end
    run_len(3'd2, n);
    n_cmp++;
    if (n !== 2) begin n_bad++; $display("FAIL max_ns_yellow_len: got %0d want 2", n); end
    run_len(3'd0, n);
    n_cmp++;
    if (n !== 1 || phase !== 3'd3) begin n_bad++; $display("FAIL max_allred_to_ew: len %0d ph %0d want 1 3", n, phase); end
    run_len(3'd3, n);
    n_cmp++;
    if (n !== 12) begin n_bad++; $display("FAIL ew_max_green_len: got %0d want 12", n); end
    run_len(3'd4, n);
    n_cmp++;
    if (n !== 2) begin n_bad++; $display("FAIL ew_yellow_len: got %0d want 2", n); end
    run_len(3'd0, n);
    n_cmp++;
    if (n !== 1 || phase !== 3'd1) begin n_bad++; $display("FAIL alternate_back_ns: len %0d ph %0d want 1 1", n, phase); end
  endtask

  task automatic test_rest_in_green();
    int bad_rest;
    do_reset();
    sensor_ns = 1'b1;
    tick();
    bad_rest = 0;
    for (int i = 0; i < 50; i++) begin
      if (phase !== 3'd1 || outs !== O_NSGRN) bad_rest++;
      tick();
    end
    n_cmp++;
    if (bad_rest !== 0) begin n_bad++; $display("FAIL rest_in_green: %0d bad cycles, want 0", bad_rest); end
    sensor_ns = 1'b0;
  endtask

  task automatic test_ped_walk();
    int n;
    do_reset();
    sensor_ew = 1'b1;
    tick();
    // Pedestrian arrives; EW vehicle clears so green can end at the minimum.
    ped_req   = 1'b1;
    sensor_ew = 1'b0;
    tick();
    ped_req = 1'b0;
    run_len(3'd3, n);
    n_cmp++;
    if (n + 1 !== 4) begin n_bad++; $display("FAIL ew_green_before_walk: got %0d want 4", n + 1); end
    run_len(3'd4, n);
    run_len(3'd0, n);
    n_cmp++;
    if (phase !== 3'd5 || outs !== O_WALK1) begin n_bad++; $display("FAIL walk_entry: ph %0d lamps %b want 5 %b", phase, outs, O_WALK1); end
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    n_cmp++;
    if (outs !== O_WALK) begin n_bad++; $display("FAIL walk_ack_pulse: got %b want %b", outs, O_WALK); end
    run_len(3'd5, n);
    n_cmp++;
    if (n + 1 !== 6) begin n_bad++; $display("FAIL walk_len: got %0d want 6", n + 1); end
    run_len(3'd0, n);
    n_cmp++;
    if (phase !== 3'd5 || outs !== O_WALK1) begin n_bad++; $display("FAIL walk_relatch: ph %0d lamps %b want 5 %b", phase, outs, O_WALK1); end
    run_len(3'd5, n);
    n_cmp++;
    if (n !== 6 || phase !== 3'd0) begin n_bad++; $display("FAIL second_walk: len %0d ph %0d want 6 0", n, phase); end
  endtask

  task automatic test_back_to_back();
    int n;
    int bad_idle;
    do_reset();
    sensor_ns = 1'b1;
    sensor_ew = 1'b1;
    ped_req   = 1'b1;
    tick();
    sensor_ns = 1'b0;
    sensor_ew = 1'b0;
    ped_req   = 1'b0;
    n_cmp++;
    if (phase !== 3'd5 || outs !== O_WALK1) begin n_bad++; $display("FAIL ped_first: ph %0d lamps %b want 5 %b", phase, outs, O_WALK1); end
    run_len(3'd5, n);
    run_len(3'd0, n);
    n_cmp++;
    if (phase !== 3'd1) begin n_bad++; $display("FAIL ns_after_walk: got %0d want 1", phase); end
    run_len(3'd1, n);
    n_cmp++;
    if (n !== 4) begin n_bad++; $display("FAIL b2b_ns_len: got %0d want 4", n); end
    run_len(3'd2, n);
    run_len(3'd0, n);
    n_cmp++;
    if (phase !== 3'd3) begin n_bad++; $display("FAIL ew_after_ns: got %0d want 3", phase); end
    sensor_ns = 1'b1;
    tick();
    sensor_ns = 1'b0;
    run_len(3'd3, n);
    run_len(3'd4, n);
    run_len(3'd0, n);
    sensor_ew = 1'b1;
    tick();
    sensor_ew = 1'b0;
    run_len(3'd1, n);
    n_cmp++;
    if (phase !== 3'd2) begin n_bad++; $display("FAIL reach_ns_yellow: got %0d want 2", phase); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (phase !== 3'd0 || outs !== O_ALLRED) begin n_bad++; $display("FAIL mid_reset: ph %0d lamps %b want 0 %b", phase, outs, O_ALLRED); end
    bad_idle = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (phase !== 3'd0) bad_idle++;
    end
    n_cmp++;
    if (bad_idle !== 0) begin n_bad++; $display("FAIL latches_cleared: %0d non-idle cycles, want 0", bad_idle); end
  endtask

  initial begin
    test_reset();
    test_min_green();
    test_max_green();
    test_rest_in_green();
    test_ped_walk();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
